// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
package fb_arb_pkg;

  localparam int FB_H_RES  = 640;
  localparam int FB_V_RES  = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 8;

  // Operation driven onto the single OCM port in the current cycle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } port_op_e;

  // One posted write waiting for a free port slot.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wfifo_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO for the frame-buffer arbiter. Circular buffer with
// head/tail pointers one bit wider than the slot index so full and empty
// are told apart. With FB_ARB_RAW_BYPASS_EN defined it also exposes every
// slot, the per-slot valid bits and the head index for the read bypass.
import fb_arb_pkg::*;

module fb_wr_fifo #(
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wfifo_entry_t     push_entry,
  input  logic             pop,
  output wfifo_entry_t     head,
  output logic             full,
  output logic             empty
`ifdef FB_ARB_RAW_BYPASS_EN
  ,
  output wfifo_entry_t     entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [IDX_W-1:0] head_idx
`endif
);

  wfifo_entry_t     slots [DEPTH];
  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;
  logic [IDX_W:0]   count;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (IDX_W+1)'(DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign head  = slots[rd_ptr[IDX_W-1:0]];

  // Pointer update; a push into a full FIFO or a pop from an empty one is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Slot storage; contents are meaningless outside the valid window so no reset.
  always_ff @(posedge clk) begin
    if (push && !full) slots[wr_ptr[IDX_W-1:0]] <= push_entry;
  end

`ifdef FB_ARB_RAW_BYPASS_EN
  assign entries  = slots;
  assign head_idx = rd_ptr[IDX_W-1:0];

  // A slot is valid when its distance from the head is below the fill count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [IDX_W-1:0] age;
      age = IDX_W'(i) - rd_ptr[IDX_W-1:0];
      valid[i] = ({1'b0, age} < count);
    end
  end
`endif

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port OCM arbiter: scanout reads always win, paint writes are posted
// into fb_wr_fifo and drained on cycles without a read.
// Optional feature macro: FB_ARB_RAW_BYPASS_EN (read-after-posted-write bypass).
//
// Handshake: a write transfers on the rising edge where wr_valid & wr_ready
// are both 1; wr_ready depends only on registered FIFO state. rd_req has no
// ready: every sampled request issues and returns exactly one RE_OCM pulse
// MEM_LAT+1 edges later unless Reset intervenes.
import fb_arb_pkg::*;

module fb_port_arbiter #(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int MEM_LAT     = 1,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              RE_OCM,
  output logic [DATA_W-1:0] PixelColor,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wfifo_empty,
  output port_op_e          dbg_op
);

  localparam int IDX_W = $clog2(WFIFO_DEPTH);

  port_op_e       op;
  port_op_e       op_nxt;
  wfifo_entry_t   push_entry;
  wfifo_entry_t   head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic [DATA_W-1:0] rsp_data;

  // rsp_chain[0] is the live read strobe, rsp_chain[i+1] is rsp_vld[i].
  logic [MEM_LAT:0]   rsp_vld;
  logic [MEM_LAT+1:0] rsp_chain;

  assign push_entry  = {wr_addr, wr_data};
  assign push        = wr_valid & wr_ready;
  assign pop         = (op_nxt == OP_WRITE);
  assign wr_ready    = ~fifo_full;
  assign wfifo_empty = fifo_empty;
  assign dbg_op      = op;
  assign rsp_chain   = {rsp_vld, mem_re};
  assign RE_OCM      = rsp_vld[MEM_LAT];

`ifdef FB_ARB_RAW_BYPASS_EN
  wfifo_entry_t      entries [WFIFO_DEPTH];
  logic [WFIFO_DEPTH-1:0] fifo_valid;
  logic [IDX_W-1:0]  head_idx;
  logic [IDX_W-1:0]  scan_idx;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;
  logic [MEM_LAT:0]  byp_hit_p;
  logic [DATA_W-1:0] byp_data_p [MEM_LAT+1];
`endif

  fb_wr_fifo #(.DEPTH(WFIFO_DEPTH)) u_wr_fifo (
    .clk        (Clk),
    .rst        (Reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
`ifdef FB_ARB_RAW_BYPASS_EN
    ,
    .entries    (entries),
    .valid      (fifo_valid),
    .head_idx   (head_idx)
`endif
  );

  // Port priority: read, else drain one posted write, else idle.
  always_comb begin
    op_nxt = OP_IDLE;
    if (rd_req)           op_nxt = OP_READ;
    else if (!fifo_empty) op_nxt = OP_WRITE;
  end

  // Registered port op and OCM strobes; address/data hold while idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op        <= OP_IDLE;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      op <= op_nxt;
      unique case (op_nxt)
        OP_READ: begin
          mem_re   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= rd_addr;
        end
        OP_WRITE: begin
          mem_re    <= 1'b0;
          mem_we    <= 1'b1;
          mem_addr  <= head.addr;
          mem_wdata <= head.data;
        end
        default: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef FB_ARB_RAW_BYPASS_EN
  // Scan from oldest to newest so the newest matching posted write wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    scan_idx = '0;
    for (int a = 0; a < WFIFO_DEPTH; a++) begin
      scan_idx = head_idx + IDX_W'(a);
      if (fifo_valid[scan_idx] && (entries[scan_idx].addr == rd_addr)) begin
        byp_hit  = 1'b1;
        byp_data = entries[scan_idx].data;
      end
    end
  end

  // Bypass snapshot travels alongside the read strobe through the response pipe.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      byp_hit_p <= '0;
      for (int i = 0; i <= MEM_LAT; i++) byp_data_p[i] <= '0;
    end else begin
      byp_hit_p[0]  <= rd_req & byp_hit;
      byp_data_p[0] <= byp_data;
      for (int i = 1; i <= MEM_LAT; i++) begin
        byp_hit_p[i]  <= byp_hit_p[i-1];
        byp_data_p[i] <= byp_data_p[i-1];
      end
    end
  end

  assign rsp_data = byp_hit_p[MEM_LAT] ? byp_data_p[MEM_LAT] : mem_rdata;
`else
  assign rsp_data = mem_rdata;
`endif

  // Read-response valid pipe; PixelColor is captured when OCM data is valid.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_vld    <= '0;
      PixelColor <= '0;
    end else begin
      rsp_vld    <= rsp_chain[MEM_LAT:0];
      PixelColor <= rsp_chain[MEM_LAT] ? rsp_data : '0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with an OCM model, a queue-based
// reference model and a per-cycle compare process.
module tb_fb_port_arbiter;
  import fb_arb_pkg::*;

  localparam int AW    = 19;
  localparam int DW    = 8;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  logic          Clk;
  logic          Reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          RE_OCM;
  logic [DW-1:0] PixelColor;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          wfifo_empty;
  port_op_e      dbg_op;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .WFIFO_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .RE_OCM(RE_OCM), .PixelColor(PixelColor), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .wfifo_empty(wfifo_empty),
    .dbg_op(dbg_op)
  );

  // ---------------- OCM model: 1-cycle read latency, unwritten word = addr[7:0] ----------------
  logic [DW-1:0] ocm [logic [AW-1:0]];
  initial begin
    forever begin
      @(posedge Clk);
      if (mem_we) ocm[mem_addr] = mem_wdata;
      if (mem_re) mem_rdata <= ocm.exists(mem_addr) ? ocm[mem_addr] : mem_addr[7:0];
    end
  end

  // ---------------- reference model ----------------
  logic [AW+DW-1:0] exp_q[$];         // posted writes, oldest first
  rsp_t             rsp_q[$];         // expected read results with due cycle
  logic [DW-1:0]    img [logic [AW-1:0]];  // memory image after committed writes
  int               cyc = 0;
  logic             exp_re = 1'b0, exp_we = 1'b0;
  logic [AW-1:0]    exp_addr = '0;
  logic [DW-1:0]    exp_wdata = '0;
  port_op_e         exp_op = OP_IDLE;

  function automatic logic [DW-1:0] img_rd(logic [AW-1:0] a);
    return img.exists(a) ? img[a] : a[7:0];
  endfunction

  initial begin
    logic             push_ok;
    logic [DW-1:0]    d;
    logic [AW+DW-1:0] e;
    forever begin
      @(posedge Clk);
      cyc++;
      if (Reset) begin
        exp_q.delete();
        rsp_q.delete();
        exp_re = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        exp_op = OP_IDLE;
      end else begin
        push_ok = wr_valid && (exp_q.size() < DEPTH);
        if (rd_req) begin
          d = img_rd(rd_addr);
`ifdef FB_ARB_RAW_BYPASS_EN
          for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i][AW+DW-1:DW] == rd_addr) d = exp_q[i][DW-1:0];
`endif
          rsp_q.push_back('{due: cyc + LAT + 1, data: d});
          exp_op = OP_READ; exp_re = 1'b1; exp_we = 1'b0; exp_addr = rd_addr;
        end else if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          img[e[AW+DW-1:DW]] = e[DW-1:0];
          exp_op = OP_WRITE; exp_re = 1'b0; exp_we = 1'b1;
          exp_addr = e[AW+DW-1:DW]; exp_wdata = e[DW-1:0];
        end else begin
          exp_op = OP_IDLE; exp_re = 1'b0; exp_we = 1'b0;
        end
        if (push_ok) exp_q.push_back({wr_addr, wr_data});
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  initial begin
    logic          e_re;
    logic [DW-1:0] e_px;
    forever begin
      @(negedge Clk);
      e_re = 1'b0;
      e_px = '0;
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        e_re = 1'b1;
        e_px = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end
      check("cmp_re_ocm",  32'(RE_OCM), 32'(e_re));
      check("cmp_pixel",   32'(PixelColor), 32'(e_px));
      check("cmp_mem_re",  32'(mem_re), 32'(exp_re));
      check("cmp_mem_we",  32'(mem_we), 32'(exp_we));
      check("cmp_mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("cmp_mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      check("cmp_wr_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH));
      check("cmp_wfifo_empty", 32'(wfifo_empty), 32'(exp_q.size() == 0));
      check("cmp_op", 32'(dbg_op), 32'(exp_op));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
  endtask

  // Single read issued from idle; result checked MEM_LAT+1 edges later.
  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_req  = 1'b1;
    rd_addr = a;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    check({name, "_re"}, 32'(RE_OCM), 32'd1);
    check({name, "_px"}, 32'(PixelColor), 32'(d));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    Reset = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    check("rst_re_ocm", 32'(RE_OCM), 32'd0);
    check("rst_pixel", 32'(PixelColor), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_wfifo_empty", 32'(wfifo_empty), 32'd1);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    Reset = 1'b0;

    // Three back-to-back reads from 0x10.
    rd_req = 1'b1; rd_addr = 19'h00010; tick();
    rd_addr = 19'h00011; tick();
    rd_addr = 19'h00012; tick();
    rd_req = 1'b0;
    check("t1_re0", 32'(RE_OCM), 32'd1);
    check("t1_px0", 32'(PixelColor), 32'h10);
    tick();
    check("t1_px1", 32'(PixelColor), 32'h11);
    tick();
    check("t1_px2", 32'(PixelColor), 32'h12);
    tick();
    check("t1_re_end", 32'(RE_OCM), 32'd0);

    // Fill the FIFO under continuous reads, then drain.
    rd_req = 1'b1; rd_addr = 19'h00020;
    for (int i = 0; i < 4; i++) push_word(19'h00100 + 19'(i), 8'hA0 + 8'(i));
    wr_valid = 1'b0;
    check("t2_full_ready", 32'(wr_ready), 32'd0);
    check("t2_no_we", 32'(mem_we), 32'd0);
    tick(); tick();
    rd_req = 1'b0;
    repeat (3) tick();
    check("t2_not_empty", 32'(wfifo_empty), 32'd0);
    tick();
    check("t2_empty", 32'(wfifo_empty), 32'd1);
    read_check("t2_rb", 19'h00102, 8'hA2);

    // Alternating reads with two pending writes.
    rd_req = 1'b1; rd_addr = 19'h00030;
    push_word(19'h00200, 8'h55);
    push_word(19'h00201, 8'h66);
    wr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_req  = (i % 2 == 0);
      rd_addr = 19'h00030 + 19'(i);
      tick();
    end
    rd_req = 1'b0;
    repeat (3) tick();
    read_check("t3_rb", 19'h00201, 8'h66);

    // Read of an address with a write still posted.
    rd_req = 1'b1; rd_addr = 19'h00020;
    push_word(19'h4B000, 8'h3C);
    wr_valid = 1'b0;
    rd_addr = 19'h4B000;
    tick();
    rd_addr = 19'h00020;
    tick();
    tick();
    check("t4_re", 32'(RE_OCM), 32'd1);
`ifdef FB_ARB_RAW_BYPASS_EN
    check("t4_px", 32'(PixelColor), 32'h3C);
`else
    check("t4_px", 32'(PixelColor), 32'h00);
`endif
    rd_req = 1'b0;
    repeat (3) tick();
    read_check("t4_rb", 19'h4B000, 8'h3C);

    // Full FIFO: pop and wr_valid in the same cycle.
    rd_req = 1'b1; rd_addr = 19'h00040;
    for (int i = 0; i < 4; i++) push_word(19'h00310 + 19'(i), 8'h10 + 8'(i));
    check("t5_full", 32'(wr_ready), 32'd0);
    rd_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 19'h00300; wr_data = 8'h77;
    tick();
    check("t5_ready_after_pop", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    repeat (6) tick();
    read_check("t5_rb_first", 19'h00310, 8'h10);
    read_check("t5_rb_late", 19'h00300, 8'h77);

    // Reset one cycle after a read issue with two posted writes.
    rd_req = 1'b1; rd_addr = 19'h00050;
    push_word(19'h004A5, 8'h11);
    push_word(19'h004A6, 8'h22);
    wr_valid = 1'b0;
    tick();
    Reset = 1'b1; rd_req = 1'b0;
    #1;
    check("t6_re_ocm", 32'(RE_OCM), 32'd0);
    check("t6_mem_re", 32'(mem_re), 32'd0);
    check("t6_wr_ready", 32'(wr_ready), 32'd1);
    check("t6_empty", 32'(wfifo_empty), 32'd1);
    tick(); tick();
    Reset = 1'b0;
    repeat (6) tick();
    read_check("t6_discard", 19'h004A5, 8'hA5);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates the single-port on-chip frame buffer (OCM) between the VGA scanout reader and the BFS paint writer. Scanout reads always win so the palette never misses a pixel. Writes are posted into a small FIFO and drained on cycles with no read. The block produces `RE_OCM` and the 8-bit color index consumed by the palette stage.

## Interface
Parameters:
- `ADDR_W`, 19 — frame-buffer word address width (640×480 = 307200 words).
- `DATA_W`, 8 — color index width.
- `MEM_LAT`, 1 — OCM read latency in cycles, from registered `mem_re` to valid `mem_rdata`.
- `WFIFO_DEPTH`, 4 — posted-write FIFO depth; must be a power of two, ≥ 2.

Ports:
- `Clk` in 1 — pixel clock; single clock domain.
- `Reset` in 1 — asynchronous, active-high.
- `rd_req` in 1 — scanout read request, sampled each edge.
- `rd_addr` in ADDR_W — scanout address.
- `RE_OCM` out 1 — read data valid; feeds palette `RE_OCM`.
- `PixelColor` out DATA_W — read data, valid when `RE_OCM`=1.
- `wr_valid` in 1 — writer has a word.
- `wr_addr` in ADDR_W — write address.
- `wr_data` in DATA_W — write data.
- `wr_ready` out 1 — FIFO can accept; transfer when `wr_valid & wr_ready`.
- `mem_addr` out ADDR_W — OCM address (registered).
- `mem_wdata` out DATA_W — OCM write data (registered).
- `mem_we` out 1 — OCM write strobe (registered).
- `mem_re` out 1 — OCM read strobe (registered).
- `mem_rdata` in DATA_W — OCM read data.
- `wfifo_empty` out 1 — no posted writes pending; used by the BFS engine before a frame swap.

## Operation
- Port op register `op` with states OP_IDLE, OP_READ, OP_WRITE. The next state is chosen every edge:
  - `rd_req`=1 → OP_READ. This happens regardless of FIFO state.
  - Otherwise, FIFO not empty → OP_WRITE, which pops the head.
  - Otherwise → OP_IDLE.
- OP_READ: `mem_re`=1, `mem_addr`=sampled `rd_addr`, `mem_we`=0.
- OP_WRITE: `mem_we`=1, with `mem_addr`/`mem_wdata` taken from the FIFO head. `mem_re`=0.
- OP_IDLE: `mem_re`=`mem_we`=0. `mem_addr`/`mem_wdata` hold their previous values.
- Read response pipeline is a valid shift register of length MEM_LAT+1. `RE_OCM` is its tail. `PixelColor` = `mem_rdata` when `RE_OCM`, else 0.
- FIFO push occurs on `wr_valid & wr_ready`. `wr_ready` = (count < WFIFO_DEPTH), taken from the registered count.
  - When full, a same-cycle pop does not raise `wr_ready` until the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Writes are committed to memory in FIFO order. Writes are never dropped.
- Writer starvation is acceptable during continuous reads; horizontal/vertical blanking guarantees drain slots.

## Timing
- Reset values: `op`=OP_IDLE; FIFO empty; `wr_ready`=1; `wfifo_empty`=1; `RE_OCM`=0; `PixelColor`=0; all `mem_*`=0; response pipeline cleared.
- Read latency: `rd_req` sampled at edge k → `mem_re` high in cycle k → `RE_OCM`/`PixelColor` valid MEM_LAT+1 edges after k, for exactly one cycle per request.
- Back-to-back reads give one result per cycle with no bubbles.
- Write: accepted at edge k into an empty FIFO with no read → `mem_we` high in the cycle following edge k+1.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately.
  - In-flight reads produce no `RE_OCM`.
  - Posted writes are discarded.

## Configuration
- `FB_ARB_RAW_BYPASS_EN` defined: at read issue, `rd_addr` is compared against all valid FIFO entries. On a hit, the newest matching entry's data is snapshotted into the response pipeline and returned in place of `mem_rdata`, at the same latency.
- Undefined: no comparison is made. A read of an address with a pending write returns the pre-write memory contents.

## Structure
- `fb_arb_pkg`:
  - `port_op_e` (OP_IDLE/OP_READ/OP_WRITE).
  - Constants `FB_H_RES`=640, `FB_V_RES`=480, `FB_ADDR_W`=19.
  - `wfifo_entry_t` struct {addr, data}.
- One sub-module: `fb_wr_fifo`.
  - Circular buffer with head/tail pointers one bit wider than the index (for full/empty).
  - Exposes all entries plus valid bits for the bypass compare.

## Test plan
- Reset release, `rd_req`=1 at address 0x00010 for 3 cycles with `mem_rdata` = address[7:0] → `RE_OCM` high for 3 consecutive cycles starting MEM_LAT+1 edges after the first sample; `PixelColor` = 0x10, 0x11, 0x12.
- `rd_req` held high; writer pushes 4 words → `wr_ready` drops after the 4th push and `mem_we` stays 0. Then `rd_req`=0 → 4 writes issue on 4 consecutive cycles in push order, after which `wfifo_empty`=1.
- Alternating `rd_req` 1/0 with 2 pending writes → each write issues only in cycles where no read is issued; read latency is unchanged.
- With `FB_ARB_RAW_BYPASS_EN`: push write (0x4B000, 0x3C) while reads run, then read 0x4B000 before the drain → `PixelColor`=0x3C. Without the macro → the old memory value.
- Full FIFO with simultaneous pop and `wr_valid` → no push that cycle; `wr_ready`=1 the next cycle.
- Assert `Reset` one cycle after a read issue with 2 posted writes → no `RE_OCM` pulse, no further `mem_we`, `wr_ready`=1.
